// File: rtl/sat_pkg.sv
// Shared types and helpers for the shared saturation arbiter.
// Widths are carried at full size so one function serves any IW/OW/N.
package sat_pkg;

  localparam int SW   = 64;
  localparam int MAXN = 64;
  localparam int IDXW = 6;

  typedef struct packed {
    logic          sat;
    logic [SW-1:0] y;
  } sat_t;

  typedef struct packed {
    logic            found;
    logic [IDXW-1:0] idx;
  } pick_t;

  function automatic logic [SW-1:0] sat_max(input int ow);
    return (SW'(1) << (ow - 1)) - SW'(1);
  endfunction

  function automatic logic [SW-1:0] sat_min(input int ow);
    return ~sat_max(ow);
  endfunction

  // x arrives sign-extended; it fits when everything above bit ow-2
  // is pure sign extension.
  function automatic sat_t sat_f(
    input logic signed [SW-1:0] x,
    input int                   ow
  );
    sat_t              r;
    logic signed [SW-1:0] hi;
    hi    = x >>> (ow - 1);
    r.sat = !((hi == '0) || (hi == '1));
    if (!r.sat) begin
      r.y = x;
    end else if (x[SW-1]) begin
      r.y = sat_min(ow);
    end else begin
      r.y = sat_max(ow);
    end
    return r;
  endfunction

  function automatic pick_t rr_pick(
    input logic [MAXN-1:0] valid,
    input logic [IDXW-1:0] ptr,
    input int              n
  );
    pick_t r;
    int    c;
    r = '0;
    c = 0;
    for (int i = 1; i <= MAXN; i++) begin
      if (i <= n && !r.found) begin
        c = int'(ptr) + i;
        if (c >= n) begin
          c = c - n;
        end
        if (valid[c[IDXW-1:0]]) begin
          r.found = 1'b1;
          r.idx   = c[IDXW-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_share_rr.sv
// Combinational round-robin picker: first valid channel after ptr.
// Search wraps; found is low when no channel is valid.
module sat_share_rr
  import sat_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] grant,
  output logic                 found
);

  localparam int CHW = $clog2(N);

  pick_t pick;
  logic  unused_idx_hi;

  always_comb begin
    pick          = rr_pick(MAXN'(valid), IDXW'(ptr), N);
    grant         = pick.idx[CHW-1:0];
    found         = pick.found;
    unused_idx_hi = ^pick.idx[IDXW-1:CHW];
  end

endmodule

// File: rtl/sat_share_arb.sv
// N channels share one signed IW->OW saturation stage via round-robin.
// Per-channel clamp counters are readable and clearable.
module sat_share_arb
  import sat_pkg::*;
#(
  parameter int N     = 4,
  parameter int IW    = 10,
  parameter int OW    = 9,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req_valid,
  input  logic [N*IW-1:0]        req_data,
  output logic [N-1:0]           req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OW-1:0]          out_data,
  output logic [$clog2(N)-1:0]   out_chan,
  output logic                   out_sat,
  input  logic [$clog2(N)-1:0]   cnt_sel,
  output logic [CNT_W-1:0]       cnt_value,
  input  logic                   cnt_clr
);

  localparam int CHW = $clog2(N);

  logic                 adv;
  logic                 found;
  logic                 grant;
  logic [CHW-1:0]       g;
  logic signed [IW-1:0] x;
  sat_t                 s;
  logic                 unused_sat_hi;

  logic                 out_valid_q, out_valid_d;
  logic [OW-1:0]        out_data_q, out_data_d;
  logic [CHW-1:0]       out_chan_q, out_chan_d;
  logic                 out_sat_q, out_sat_d;
  logic [CHW-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q [N];
  logic [CNT_W-1:0]     cnt_d [N];

  sat_share_rr #(
    .N(N)
  ) u_rr (
    .valid(req_valid),
    .ptr  (ptr_q),
    .grant(g),
    .found(found)
  );

  always_comb begin
    adv           = !out_valid_q || out_ready;
    grant         = adv && found;
    req_ready     = grant ? (N'(1) << g) : '0;
    x             = req_data[g*IW +: IW];
    s             = sat_f(SW'(x), OW);
    unused_sat_hi = ^s.y[SW-1:OW];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_sat_d   = out_sat_q;
    ptr_d       = ptr_q;
    if (grant) begin
      out_valid_d = 1'b1;
      out_data_d  = s.y[OW-1:0];
      out_chan_d  = g;
      out_sat_d   = s.sat;
      ptr_d       = g;
    end else if (adv) begin
      out_valid_d = 1'b0;
    end
  end

  // Clear beats a same-cycle increment on the selected channel.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      cnt_d[k] = cnt_q[k];
      if (grant && s.sat && g == CHW'(k)
          && cnt_q[k] != {CNT_W{1'b1}}) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
      if (cnt_clr && cnt_sel == CHW'(k)) begin
        cnt_d[k] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_sat_q   <= 1'b0;
      ptr_q       <= CHW'(N - 1);
      for (int k = 0; k < N; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_sat_q   <= out_sat_d;
      ptr_q       <= ptr_d;
      for (int k = 0; k < N; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_sat   = out_sat_q;
  assign cnt_value = cnt_q[cnt_sel];

endmodule

// File: tb/tb_sat_share_arb.sv
// Directed bench for sat_share_arb (N=4, IW=10, OW=9, CNT_W=4).
// Expected values are hand-derived constants.
module tb_sat_share_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [39:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_sat;
  logic [1:0]  cnt_sel;
  logic [3:0]  cnt_value;
  logic        cnt_clr;

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0] fdat [4];
  logic [8:0] fexp [4];

  sat_share_arb #(
    .N(4), .IW(10), .OW(9), .CNT_W(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_chan (out_chan),
    .out_sat  (out_sat),
    .cnt_sel  (cnt_sel),
    .cnt_value(cnt_value),
    .cnt_clr  (cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  task automatic load_all();
    for (int k = 0; k < 4; k++) begin
      req_data[k*10 +: 10] = fdat[k];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_data = '0;
    out_ready = 1'b1; cnt_sel = '0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 9'h0
        || out_chan !== 2'd0 || out_sat !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out: v=%b d=%h c=%0d s=%b want 0",
               out_valid, out_data, out_chan, out_sat);
    end
    #2 rst_n = 1'b1;
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || req_ready !== 4'b0) begin
      n_bad++;
      $display("FAIL idle: v=%b rdy=%b want 0/0000",
               out_valid, req_ready);
    end
    for (int k = 0; k < 4; k++) begin
      cnt_sel = 2'(k);
      #1;
      n_cmp++;
      if (cnt_value !== 4'd0) begin
        n_bad++;
        $display("FAIL reset_cnt%0d: got %0d want 0", k, cnt_value);
      end
    end
  endtask

  task automatic test_passthrough();
    req_data[20 +: 10] = 10'd100;
    req_valid = 4'b0100;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_bad++;
      $display("FAIL pass_rdy: got %b want 0100", req_ready);
    end
    step();
    req_valid = '0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 9'd100
        || out_chan !== 2'd2 || out_sat !== 1'b0) begin
      n_bad++;
      $display("FAIL pass_out: v=%b d=%h c=%0d s=%b want 1/064/2/0",
               out_valid, out_data, out_chan, out_sat);
    end
    cnt_sel = 2'd2;
    #1;
    n_cmp++;
    if (cnt_value !== 4'd0) begin
      n_bad++;
      $display("FAIL pass_cnt: got %0d want 0", cnt_value);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL pass_drain: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_clamp();
    req_data[10 +: 10] = 10'h1FF;
    req_valid = 4'b0010;
    step();
    n_cmp++;
    if (out_data !== 9'h0FF || out_sat !== 1'b1
        || out_chan !== 2'd1 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL clamp_pos: d=%h s=%b c=%0d want 0ff/1/1",
               out_data, out_sat, out_chan);
    end
    req_data[10 +: 10] = 10'h200;
    step();
    req_valid = '0;
    n_cmp++;
    if (out_data !== 9'h100 || out_sat !== 1'b1
        || out_chan !== 2'd1) begin
      n_bad++;
      $display("FAIL clamp_neg: d=%h s=%b c=%0d want 100/1/1",
               out_data, out_sat, out_chan);
    end
    cnt_sel = 2'd1;
    #1;
    n_cmp++;
    if (cnt_value !== 4'd2) begin
      n_bad++;
      $display("FAIL clamp_cnt: got %0d want 2", cnt_value);
    end
    step();
  endtask

  task automatic test_fairness();
    logic [1:0] seq [5];
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2;
    seq[3] = 2'd3; seq[4] = 2'd0;
    pulse_reset();
    load_all();
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_chan !== seq[i]
          || out_data !== fexp[seq[i]]) begin
        n_bad++;
        $display("FAIL rr%0d: c=%0d d=%h want %0d/%h",
                 i, out_chan, out_data, seq[i], fexp[seq[i]]);
      end
    end
    out_ready = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0) begin
      n_bad++;
      $display("FAIL bp_rdy: got %b want 0000", req_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_chan !== 2'd0
          || out_data !== fexp[0] || req_ready !== 4'b0) begin
        n_bad++;
        $display("FAIL bp_hold%0d: v=%b c=%0d d=%h rdy=%b",
                 i, out_valid, out_chan, out_data, req_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_bad++;
      $display("FAIL bp_resume_rdy: got %b want 0010", req_ready);
    end
    for (int i = 1; i < 3; i++) begin
      step();
      n_cmp++;
      if (out_chan !== 2'(i) || out_data !== fexp[i]) begin
        n_bad++;
        $display("FAIL bp_resume%0d: c=%0d d=%h want %0d/%h",
                 i, out_chan, out_data, i, fexp[i]);
      end
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_cnt_limit();
    req_data[30 +: 10] = 10'h1FF;
    req_valid = 4'b1000;
    cnt_sel = 2'd3;
    for (int i = 0; i < 10; i++) step();
    n_cmp++;
    if (cnt_value !== 4'd10) begin
      n_bad++;
      $display("FAIL cnt_mid: got %0d want 10", cnt_value);
    end
    for (int i = 0; i < 10; i++) step();
    n_cmp++;
    if (cnt_value !== 4'd15) begin
      n_bad++;
      $display("FAIL cnt_sat: got %0d want 15", cnt_value);
    end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    n_cmp++;
    if (cnt_value !== 4'd0) begin
      n_bad++;
      $display("FAIL cnt_clr_wins: got %0d want 0", cnt_value);
    end
    cnt_sel = 2'd0;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    cnt_sel = 2'd3;
    #1;
    n_cmp++;
    if (cnt_value !== 4'd1) begin
      n_bad++;
      $display("FAIL cnt_clr_other: got %0d want 1", cnt_value);
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_async_reset();
    load_all();
    req_valid = 4'b1111;
    step();
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL ar_pre: out_valid got %b want 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 9'h0 || cnt_value !== 4'd0) begin
      n_bad++;
      $display("FAIL ar_drop: v=%b d=%h cnt=%0d want 0/000/0",
               out_valid, out_data, cnt_value);
    end
    #1 rst_n = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL ar_rdy: got %b want 0001", req_ready);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== fexp[0]) begin
      n_bad++;
      $display("FAIL ar_first: v=%b c=%0d d=%h want 1/0/%h",
               out_valid, out_chan, out_data, fexp[0]);
    end
    req_valid = '0;
    step();
  endtask

  initial begin
    fdat[0] = 10'd11;  fexp[0] = 9'd11;
    fdat[1] = 10'd22;  fexp[1] = 9'd22;
    fdat[2] = 10'h3F0; fexp[2] = 9'h1F0;
    fdat[3] = 10'd200; fexp[3] = 9'd200;
    test_reset();
    test_passthrough();
    test_clamp();
    test_fairness();
    test_cnt_limit();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
